// File: rtl/key_step_counter_if.sv
// rtl/key_step_counter_if.sv - key inputs and count outputs of key_step_counter
interface key_step_counter_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 key_up_n;
    logic                 key_down_n;
    logic                 key_clr_n;
    logic [2:0]           key_state;
    logic [2:0]           key_pulse;
    logic [CNT_WIDTH-1:0] cnt_out;
    logic                 cnt_wrap;

    modport master (
        output key_up_n, key_down_n, key_clr_n,
        input  key_state, key_pulse, cnt_out, cnt_wrap
    );

    modport slave (
        input  key_up_n, key_down_n, key_clr_n,
        output key_state, key_pulse, cnt_out, cnt_wrap
    );
endinterface

// File: rtl/key_step_counter.sv
// rtl/key_step_counter.sv - debounced up/down/clear keys with auto-repeat driving a wrapping count
module key_step_counter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int REPEAT_CYCLES   = 2500000,
    parameter int CNT_WIDTH       = 4,
    parameter int CNT_MAX         = 15
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    key_step_counter_if.slave  bus
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    logic [2:0]           w_raw;
    logic [2:0]           r_sync1;
    logic [2:0]           r_sync2;
    logic [2:0]           r_st;
    logic [DW-1:0]        r_db_cnt [3];
    logic [2:0]           r_pulse;
    rep_state_t           r_state [2];
    rep_state_t           w_state_next [2];
    logic [TW-1:0]        r_timer [2];
    logic [TW-1:0]        w_timer_next [2];
    logic [1:0]           w_rep;
    logic                 w_inc;
    logic                 w_dec;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_wrap;

    assign w_raw = {bus.key_clr_n, bus.key_down_n, bus.key_up_n};

    // Two-flop synchroniser, then a per-key counter that only accepts a
    // level after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_st    <= '1;
            r_pulse <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_pulse <= '0;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_st[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_st[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                    r_pulse[i]  <= ~r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int j = 0; j < 2; j++) begin
                r_state[j] <= IDLE;
                r_timer[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                r_state[j] <= w_state_next[j];
                r_timer[j] <= w_timer_next[j];
            end
        end
    end

    // Index 0 is the up key, index 1 the down key; a step is raised in the
    // cycle the timer reaches its terminal value.
    always_comb begin
        w_rep = '0;
        for (int j = 0; j < 2; j++) begin
            w_state_next[j] = r_state[j];
            w_timer_next[j] = r_timer[j];
            case (r_state[j])
                IDLE: begin
                    if (r_pulse[j]) begin
                        w_state_next[j] = HOLD;
                        w_timer_next[j] = '0;
                    end
                end
                HOLD: begin
                    if (r_st[j]) begin
                        w_state_next[j] = IDLE;
                        w_timer_next[j] = '0;
                    end else if (r_timer[j] == TW'(HOLD_CYCLES - 1)) begin
                        w_rep[j]        = 1'b1;
                        w_state_next[j] = REPEAT;
                        w_timer_next[j] = '0;
                    end else begin
                        w_timer_next[j] = r_timer[j] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_st[j]) begin
                        w_state_next[j] = IDLE;
                        w_timer_next[j] = '0;
                    end else if (r_timer[j] == TW'(REPEAT_CYCLES - 1)) begin
                        w_rep[j]        = 1'b1;
                        w_timer_next[j] = '0;
                    end else begin
                        w_timer_next[j] = r_timer[j] + 1'b1;
                    end
                end
                default: begin
                    w_state_next[j] = IDLE;
                    w_timer_next[j] = '0;
                end
            endcase
        end
    end

    assign w_inc = r_pulse[0] | w_rep[0];
    assign w_dec = r_pulse[1] | w_rep[1];

    // Clear wins over everything; simultaneous up and down cancel out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (r_pulse[2]) begin
                r_cnt <= '0;
            end else if (w_inc && w_dec) begin
                r_cnt <= r_cnt;
            end else if (w_inc) begin
                if (r_cnt == CNT_WIDTH'(CNT_MAX)) begin
                    r_cnt  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_dec) begin
                if (r_cnt == '0) begin
                    r_cnt  <= CNT_WIDTH'(CNT_MAX);
                    r_wrap <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.key_state = ~r_st;
    assign bus.key_pulse = r_pulse;
    assign bus.cnt_out   = r_cnt;
    assign bus.cnt_wrap  = r_wrap;
endmodule

// File: tb/tb_key_step_counter.sv
// tb/tb_key_step_counter.sv - scoreboard bench for key_step_counter
module tb_key_step_counter;
    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    typedef struct {
        logic [3:0] cnt;
        logic       wrap;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    bit   mon_en;
    logic [3:0] prev_cnt;
    int   pulse_cnt [3];
    int   both_cnt;
    exp_t exp_q [$];
    int   chg_t [$];

    key_step_counter_if #(.CNT_WIDTH(4)) bus ();

    key_step_counter #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .CNT_WIDTH      (4),
        .CNT_MAX        (15)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) pulse_cnt[i] += int'(bus.key_pulse[i]);
            if (bus.key_pulse[0] && bus.key_pulse[1]) both_cnt++;
            if (bus.cnt_out !== prev_cnt) begin
                exp_t e;
                chg_t.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: cnt_out=%0d wrap=%0b, no step expected", bus.cnt_out, bus.cnt_wrap);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.cnt_out !== e.cnt || bus.cnt_wrap !== e.wrap) begin
                        errors++;
                        $display("FAIL scoreboard_step: got cnt=%0d wrap=%0b, expected cnt=%0d wrap=%0b",
                                 bus.cnt_out, bus.cnt_wrap, e.cnt, e.wrap);
                    end
                end
                prev_cnt = bus.cnt_out;
            end else if (bus.cnt_wrap !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL stray_wrap: cnt_wrap=%0b with no count change, expected 0", bus.cnt_wrap);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) pulse_cnt[i] = 0;
        both_cnt = 0;
        chg_t.delete();
    endtask

    task automatic set_keys(input logic [2:0] k);
        bus.key_up_n   = k[0];
        bus.key_down_n = k[1];
        bus.key_clr_n  = k[2];
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d expected steps never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst_n = 1'b0;
        set_keys(3'b111);
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus.key_state !== 3'b000 || bus.key_pulse !== 3'b000 ||
                bus.cnt_out !== 4'd0 || bus.cnt_wrap !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d cycles with state=%b pulse=%b cnt=%0d wrap=%0b, expected all 0",
                     bad, bus.key_state, bus.key_pulse, bus.cnt_out, bus.cnt_wrap);
        end
        prev_cnt = 4'd0;
        mon_en   = 1'b1;
    endtask

    task automatic test_glitch();
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            set_keys(3'b110);
            tick(D - 1);
            set_keys(3'b111);
            tick(3);
        end
        tick(6);
        checks++;
        if (pulse_cnt[0] != 0 || bus.cnt_out !== 4'd0) begin
            errors++;
            $display("FAIL glitch_reject: pulses=%0d cnt=%0d, expected 0 and 0", pulse_cnt[0], bus.cnt_out);
        end
        exp_q.push_back('{cnt: 4'd1, wrap: 1'b0});
        set_keys(3'b110);
        tick(10);
        checks++;
        if (bus.key_state !== 3'b001) begin
            errors++;
            $display("FAIL key_state_held: got %b, expected 001", bus.key_state);
        end
        set_keys(3'b111);
        tick(12);
        checks++;
        if (pulse_cnt[0] != 1 || bus.cnt_out !== 4'd1) begin
            errors++;
            $display("FAIL single_press: pulses=%0d cnt=%0d, expected 1 and 1", pulse_cnt[0], bus.cnt_out);
        end
        check_drained("glitch");
    endtask

    task automatic test_auto_repeat();
        clear_stats();
        for (int v = 2; v <= 7; v++) exp_q.push_back('{cnt: 4'(v), wrap: 1'b0});
        set_keys(3'b110);
        tick(60);
        set_keys(3'b111);
        tick(30);
        check_drained("repeat");
        checks++;
        if (chg_t.size() != 6) begin
            errors++;
            $display("FAIL repeat_steps: got %0d steps, expected 6", chg_t.size());
        end else begin
            checks++;
            if (chg_t[1] - chg_t[0] != H) begin
                errors++;
                $display("FAIL repeat_hold_gap: got %0d cycles, expected %0d", chg_t[1] - chg_t[0], H);
            end
            for (int i = 2; i < 6; i++) begin
                checks++;
                if (chg_t[i] - chg_t[i-1] != R) begin
                    errors++;
                    $display("FAIL repeat_gap_%0d: got %0d cycles, expected %0d", i, chg_t[i] - chg_t[i-1], R);
                end
            end
        end
    endtask

    task automatic press(input logic [2:0] k);
        set_keys(k);
        tick(8);
        set_keys(3'b111);
        tick(12);
    endtask

    task automatic test_wrap();
        clear_stats();
        for (int v = 8; v <= 15; v++) begin
            exp_q.push_back('{cnt: 4'(v), wrap: 1'b0});
            press(3'b110);
        end
        exp_q.push_back('{cnt: 4'd0, wrap: 1'b1});
        press(3'b110);
        exp_q.push_back('{cnt: 4'd15, wrap: 1'b1});
        press(3'b101);
        check_drained("wrap");
        checks++;
        if (pulse_cnt[0] != 9 || pulse_cnt[1] != 1 || bus.cnt_out !== 4'd15) begin
            errors++;
            $display("FAIL wrap_final: up=%0d down=%0d cnt=%0d, expected 9 1 15", pulse_cnt[0], pulse_cnt[1], bus.cnt_out);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        press(3'b100);
        checks++;
        if (both_cnt != 1 || bus.cnt_out !== 4'd15) begin
            errors++;
            $display("FAIL up_down_cancel: same-cycle pulses=%0d cnt=%0d, expected 1 and 15", both_cnt, bus.cnt_out);
        end
        exp_q.push_back('{cnt: 4'd0, wrap: 1'b0});
        press(3'b010);
        check_drained("clear");
        checks++;
        if (pulse_cnt[2] != 1 || bus.cnt_out !== 4'd0) begin
            errors++;
            $display("FAIL clear_priority: clr pulses=%0d cnt=%0d, expected 1 and 0", pulse_cnt[2], bus.cnt_out);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        clear_stats();
        exp_q.push_back('{cnt: 4'd15, wrap: 1'b1});
        set_keys(3'b101);
        tick(16);
        check_drained("pre_reset");
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checks++;
        if (bus.key_state !== 3'b000 || bus.key_pulse !== 3'b000 || bus.cnt_out !== 4'd0 || bus.cnt_wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%b pulse=%b cnt=%0d wrap=%0b, expected all 0",
                     bus.key_state, bus.key_pulse, bus.cnt_out, bus.cnt_wrap);
        end
        tick(2);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus.key_pulse[1] === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 2 + D) begin
            errors++;
            $display("FAIL repress_latency: pulse after %0d cycles, expected %0d", n, 2 + D);
        end
        tick(1);
        checks++;
        if (bus.cnt_out !== 4'd15 || bus.cnt_wrap !== 1'b1 || bus.key_pulse !== 3'b000) begin
            errors++;
            $display("FAIL repress_count: cnt=%0d wrap=%0b pulse=%b, expected 15 1 000",
                     bus.cnt_out, bus.cnt_wrap, bus.key_pulse);
        end
        set_keys(3'b111);
        tick(12);
        checks++;
        if (bus.cnt_out !== 4'd15 || bus.key_state !== 3'b000) begin
            errors++;
            $display("FAIL after_release: cnt=%0d state=%b, expected 15 000", bus.cnt_out, bus.key_state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        mon_en = 1'b0;
        prev_cnt = 4'd0;
        rst_n  = 1'b0;
        set_keys(3'b111);
        test_reset();
        test_glitch();
        test_auto_repeat();
        test_wrap();
        test_back_to_back();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/key_step_counter.md
Name: key_step_counter

Overview:
- Board input-side companion to the LED/segment output path: conditions raw active-low push-buttons and produces a 4-bit count value in the same format the display blocks consume as heart_cnt.
- Three keys (up, down, clear) are synchronised, debounced and edge-detected.
- Up and down keys auto-repeat while held.
- Runs in the 25 MHz board clock domain; the output drives the water-LED, colour-LED and segment-LED blocks in place of the free-running heartbeat.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a key change (10 ms at 25 MHz); minimum 2.
- HOLD_CYCLES, 12500000, hold time after the initial press before the first auto-repeat step (0.5 s).
- REPEAT_CYCLES, 2500000, interval between auto-repeat steps (0.1 s).
- CNT_WIDTH, 4, width of the count output.
- CNT_MAX, 15, highest count value; must satisfy CNT_MAX < 2^CNT_WIDTH.

Ports:
- clk_in  input  1  25 MHz board clock
- rst_n_in  input  1  asynchronous reset, active low
- key_up_n  input  1  raw up key, active low, asynchronous to clk_in
- key_down_n  input  1  raw down key, active low, asynchronous
- key_clr_n  input  1  raw clear key, active low, asynchronous
- key_state  output  3  debounced level, 1 = pressed; bit order {clr, down, up}
- key_pulse  output  3  one-cycle press pulse per key; same bit order
- cnt_out  output  CNT_WIDTH  current count
- cnt_wrap  output  1  one-cycle pulse on wrap in either direction

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n_in is asynchronous, active-low. All flops clear immediately on assertion.
- Reset values: sync flops 1 (released); key_state 0; key_pulse 0; cnt_out 0; cnt_wrap 0; all timers 0; FSMs IDLE.
- Synchroniser: two flops per key. The raw input reaches the sync output s after 2 edges.
- Debounce, per key, with stable level st:
  - If s == st, the debounce counter clears.
  - If s != st, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while s != st: st <= s and the counter clears.
  - Net effect: st changes after DEBOUNCE_CYCLES consecutive mismatched cycles. Any glitch shorter than this is rejected.
- key_state = ~st.
- key_pulse[i] is registered and high for exactly one cycle, on the cycle after st falls (press). Release produces no pulse.
- Auto-repeat FSM, one each for up and down, with its own timer:
  - IDLE: on that key's pulse, go to HOLD with timer=0.
  - HOLD: if released, go to IDLE. If timer == HOLD_CYCLES-1, raise repeat step, go to REPEAT, timer=0. Otherwise timer++.
  - REPEAT: if released, go to IDLE. If timer == REPEAT_CYCLES-1, raise repeat step, timer=0. Otherwise timer++.
  - The clear key has no repeat.
- Step events: inc = key_pulse[0] | repeat_up; dec = key_pulse[1] | repeat_down.
- Count update, applied on the edge where the event is high, so cnt_out changes one cycle after the pulse. Priority order:
  1. key_pulse[2] (clear): cnt_out <= 0, cnt_wrap=0.
  2. inc and dec together: no change.
  3. inc: if cnt_out == CNT_MAX, then 0 and cnt_wrap=1; else +1.
  4. dec: if cnt_out == 0, then CNT_MAX and cnt_wrap=1; else -1.
- Holding the clear key does not block up/down steps after its single clear event.
- cnt_wrap is registered alongside cnt_out and is otherwise 0.
- Reset mid-debounce or mid-repeat aborts the operation. After release of reset, a key already held low must be re-debounced and produces one fresh press pulse.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, CNT_MAX=15):
- Reset, all keys high for 50 cycles -> key_state=0, key_pulse=0, cnt_out=0, cnt_wrap=0 throughout.
- key_up_n low for 3 cycles then high; repeat 5 times -> no pulse, cnt_out stays 0. Then hold low for 10 cycles -> exactly one key_pulse[0], cnt_out=1.
- Hold key_up_n low for 60 cycles -> cnt_out increments at press, then 20 cycles later, then every 8 cycles. Release stops increments. Total after the hold is 1+1+4 = 6 steps from start value.
- cnt_out=15, press up -> cnt_out=0 with cnt_wrap high one cycle. Press down -> cnt_out=15 with cnt_wrap high one cycle.
- Press up and down with identical timing -> both key_pulse bits fire in the same cycle, cnt_out unchanged. Then press clear together with up -> cnt_out=0.
- Hold key_down_n low, deassert rst_n_in mid-HOLD for 2 cycles, keep key held -> outputs zeroed immediately. One new key_pulse[1] after 2+DEBOUNCE_CYCLES cycles, then cnt_out=15.
